// File: rtl/midi_msg_ctrl.sv
// MIDI channel-message controller.
// Turns the byte stream from the MIDI UART receiver into complete channel
// messages. It handles running status, real-time bytes interleaved anywhere,
// SysEx and system-common skipping, and channel filtering. For each message
// it emits a one-cycle event strobe whose payload is registered.
//
// Handshake: a byte is taken in every cycle where rx_rdy=1, and rx_data is
// valid only in that cycle. There is no backpressure, so back-to-back
// rx_rdy pulses are accepted. Each event strobe is high for exactly one
// cycle, one clock after the rx_rdy that completed the message. The payload
// registers are valid from that cycle and hold until the next event of the
// same type.
module midi_msg_ctrl #(
    parameter logic [3:0] CHANNEL = 4'd0,
    parameter logic       OMNI    = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_rdy,
    output logic        note_on,
    output logic        note_off,
    output logic [6:0]  note,
    output logic [6:0]  velocity,
    output logic        cc_valid,
    output logic [6:0]  cc_num,
    output logic [6:0]  cc_val,
    output logic        pb_valid,
    output logic [13:0] pb_val,
    output logic        all_off,
    output logic [3:0]  msg_chan
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_D1 = 2'd1,
        WAIT_D2 = 2'd2,
        SKIP    = 2'd3
    } state_t;

    // Current message-sequencing state. Checkers can bind to it
    // hierarchically.
    state_t     state, state_nxt;
    logic [7:0] run_stat, run_stat_nxt;
    logic       run_valid, run_valid_nxt;
    logic [6:0] d1, d1_nxt;
    logic [1:0] need, need_nxt;

    // Message-complete pulse and the two data bytes of the message.
    logic       msg_done;
    logic [6:0] done_d1;
    logic [6:0] done_d2;
    logic       chan_ok;

    assign chan_ok = OMNI || (run_stat[3:0] == CHANNEL);

    // Next-state logic: classify the incoming byte and advance the sequencer.
    always_comb begin
        state_nxt     = state;
        run_stat_nxt  = run_stat;
        run_valid_nxt = run_valid;
        d1_nxt        = d1;
        need_nxt      = need;
        msg_done      = 1'b0;
        done_d1       = d1;
        done_d2       = rx_data[6:0];
        if (rx_rdy) begin
            if (rx_data >= 8'hF8) begin
                // Real-time bytes are transparent to the sequencer.
                state_nxt = state;
            end else if (rx_data[7] && (rx_data < 8'hF0)) begin
                // A channel status byte starts a new message and drops any
                // partial message.
                run_stat_nxt  = rx_data;
                run_valid_nxt = 1'b1;
                need_nxt      = ((rx_data[7:4] == 4'hC) || (rx_data[7:4] == 4'hD))
                                ? 2'd1 : 2'd2;
                state_nxt     = WAIT_D1;
            end else if (rx_data[7]) begin
                // A system common byte cancels running status. EOX returns to
                // IDLE.
                run_valid_nxt = 1'b0;
                state_nxt     = (rx_data == 8'hF7) ? IDLE : SKIP;
            end else begin
                case (state)
                    IDLE, WAIT_D1: begin
                        // A data byte in IDLE with valid running status is
                        // the first data byte of a new message.
                        if ((state == WAIT_D1) || run_valid) begin
                            if (need == 2'd2) begin
                                d1_nxt    = rx_data[6:0];
                                state_nxt = WAIT_D2;
                            end else begin
                                msg_done  = 1'b1;
                                done_d1   = rx_data[6:0];
                                state_nxt = IDLE;
                            end
                        end
                    end
                    WAIT_D2: begin
                        msg_done  = 1'b1;
                        state_nxt = IDLE;
                    end
                    default: begin
                        state_nxt = state;
                    end
                endcase
            end
        end
    end

    // Sequencer registers, plus one-cycle strobes with registered payloads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            run_stat  <= 8'h00;
            run_valid <= 1'b0;
            d1        <= 7'd0;
            need      <= 2'd0;
            note_on   <= 1'b0;
            note_off  <= 1'b0;
            cc_valid  <= 1'b0;
            pb_valid  <= 1'b0;
            all_off   <= 1'b0;
            note      <= 7'd0;
            velocity  <= 7'd0;
            cc_num    <= 7'd0;
            cc_val    <= 7'd0;
            pb_val    <= 14'h2000;
            msg_chan  <= 4'd0;
        end else begin
            state     <= state_nxt;
            run_stat  <= run_stat_nxt;
            run_valid <= run_valid_nxt;
            d1        <= d1_nxt;
            need      <= need_nxt;
            note_on   <= 1'b0;
            note_off  <= 1'b0;
            cc_valid  <= 1'b0;
            pb_valid  <= 1'b0;
            all_off   <= 1'b0;
            if (msg_done && chan_ok) begin
                case (run_stat[7:4])
                    4'h8: begin
                        note_off <= 1'b1;
                        note     <= done_d1;
                        velocity <= done_d2;
                        msg_chan <= run_stat[3:0];
                    end
                    4'h9: begin
                        // A note-on with velocity 0 is a note-off.
                        note_on  <= (done_d2 != 7'd0);
                        note_off <= (done_d2 == 7'd0);
                        note     <= done_d1;
                        velocity <= done_d2;
                        msg_chan <= run_stat[3:0];
                    end
                    4'hB: begin
                        cc_valid <= 1'b1;
                        all_off  <= (done_d1 == 7'd120) || (done_d1 == 7'd123);
                        cc_num   <= done_d1;
                        cc_val   <= done_d2;
                        msg_chan <= run_stat[3:0];
                    end
                    4'hE: begin
                        pb_valid <= 1'b1;
                        pb_val   <= {done_d2, done_d1};
                        msg_chan <= run_stat[3:0];
                    end
                    default: begin
                        // Aftertouch and program change are consumed without
                        // an event.
                        note_on <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_midi_msg_ctrl.sv
// Testbench for midi_msg_ctrl: directed MIDI sequences followed by random
// byte streams, checked against a queue-based message model via a scoreboard.
module tb_midi_msg_ctrl;

    localparam logic [3:0] TB_CHANNEL = 4'd0;
    localparam logic       TB_OMNI    = 1'b0;
    localparam int         W          = 51;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_rdy;
    logic        note_on, note_off, cc_valid, pb_valid, all_off;
    logic [6:0]  note, velocity, cc_num, cc_val;
    logic [13:0] pb_val;
    logic [3:0]  msg_chan;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] dut_snap;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    midi_msg_ctrl #(.CHANNEL(TB_CHANNEL), .OMNI(TB_OMNI)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_rdy(rx_rdy),
        .note_on(note_on), .note_off(note_off), .note(note), .velocity(velocity),
        .cc_valid(cc_valid), .cc_num(cc_num), .cc_val(cc_val),
        .pb_valid(pb_valid), .pb_val(pb_val), .all_off(all_off), .msg_chan(msg_chan)
    );

    assign dut_snap = {note_on, note_off, cc_valid, pb_valid, all_off, msg_chan,
                       note, velocity, cc_num, cc_val, pb_val};

    // ---------------- reference model ----------------
    // A message is a status byte plus a list of collected data bytes. It is
    // complete when the list reaches the length the status calls for.
    logic [7:0] m_stat;
    logic       m_valid;
    logic       m_skip;
    logic [6:0] m_data[$];
    logic [3:0] m_chan;
    logic [6:0] m_note, m_vel, m_ccn, m_ccv;
    logic [13:0] m_pb;

    function automatic logic [W-1:0] snap(input logic on, input logic off,
                                          input logic cc, input logic pb, input logic ao);
        return {on, off, cc, pb, ao, m_chan, m_note, m_vel, m_ccn, m_ccv, m_pb};
    endfunction

    task automatic model_reset();
        m_stat = 8'h00; m_valid = 1'b0; m_skip = 1'b0; m_data.delete();
        m_chan = 4'd0; m_note = 7'd0; m_vel = 7'd0; m_ccn = 7'd0; m_ccv = 7'd0;
        m_pb = 14'h2000;
    endtask

    task automatic model_complete();
        logic [6:0] a, b;
        logic [3:0] ch, hi;
        a  = m_data[0];
        b  = (m_data.size() > 1) ? m_data[1] : 7'd0;
        ch = m_stat[3:0];
        hi = m_stat[7:4];
        m_data.delete();
        if (!TB_OMNI && ch != TB_CHANNEL) return;
        case (hi)
            4'h9: begin
                m_chan = ch; m_note = a;
                if (b != 0) begin m_vel = b; exp_q.push_back(snap(1, 0, 0, 0, 0)); end
                else begin m_vel = 0; exp_q.push_back(snap(0, 1, 0, 0, 0)); end
            end
            4'h8: begin
                m_chan = ch; m_note = a; m_vel = b;
                exp_q.push_back(snap(0, 1, 0, 0, 0));
            end
            4'hB: begin
                m_chan = ch; m_ccn = a; m_ccv = b;
                exp_q.push_back(snap(0, 0, 1, 0, (a == 120 || a == 123)));
            end
            4'hE: begin
                m_chan = ch; m_pb = b * 128 + a;
                exp_q.push_back(snap(0, 0, 0, 1, 0));
            end
            default: ;
        endcase
    endtask

    task automatic model_byte(input logic [7:0] b);
        int len;
        if (b >= 8'hF8) return;
        if (b >= 8'hF0) begin
            m_valid = 1'b0; m_data.delete(); m_skip = (b != 8'hF7);
        end else if (b >= 8'h80) begin
            m_stat = b; m_valid = 1'b1; m_skip = 1'b0; m_data.delete();
        end else if (m_valid && !m_skip) begin
            m_data.push_back(b[6:0]);
            len = (m_stat[7:4] == 4'hC || m_stat[7:4] == 4'hD) ? 1 : 2;
            if (m_data.size() == len) model_complete();
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called at posedge+1; returns at posedge+1 once the byte is sampled.
    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_rdy  = 1'b1;
        model_byte(b);
        @(posedge clk); #1;
        rx_rdy  = 1'b0;
        rx_data = 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_seq(input logic [7:0] s[$]);
        foreach (s[i]) send(s[i]);
        idle(3);
    endtask

    task automatic do_reset_check(input string name);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        checks++;
        if (dut_snap !== snap(0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, dut_snap, snap(0, 0, 0, 0, 0));
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst_n && (note_on | note_off | cc_valid | pb_valid | all_off)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: got %h expected no event", dut_snap);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if (dut_snap !== e) begin
                    errors++;
                    $display("FAIL event: got %h expected %h", dut_snap, e);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] b;
        int r;
        rst_n = 1'b0; rx_rdy = 1'b0; rx_data = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        do_reset_check("reset_state");

        send_seq('{8'h90, 8'h3C, 8'h64, 8'h80, 8'h3C, 8'h00});
        send_seq('{8'h90, 8'h40, 8'h7F, 8'h41, 8'h00});
        send_seq('{8'h90, 8'hF8, 8'h45, 8'hFE, 8'h50});
        send_seq('{8'h93, 8'h3C, 8'h64});
        send_seq('{8'hF0, 8'h12, 8'h34, 8'hF7, 8'h3C, 8'h64});
        send_seq('{8'hE0, 8'h00, 8'h40});
        send_seq('{8'hB0, 8'h7B, 8'h00, 8'h78, 8'h05});
        send_seq('{8'hE0, 8'h7F, 8'h7F, 8'hC0, 8'h05, 8'hD0, 8'h10, 8'hA0, 8'h3C, 8'h40});
        send_seq('{8'hB0, 8'h07, 8'h64, 8'hF2, 8'h01, 8'h02, 8'h90, 8'h3C, 8'hFF, 8'h80, 8'h90});

        send(8'h90); idle(1); send(8'h3C); idle(2);
        do_reset_check("reset_mid_msg");
        send(8'h64); idle(3);
        checks++;
        if (dut_snap !== snap(0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL after_reset_data: got %h expected %h", dut_snap, snap(0, 0, 0, 0, 0));
        end

        for (int i = 0; i < 2000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 15) begin
                b = {1'b1, 3'($urandom_range(0, 6)),
                     ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : TB_CHANNEL};
            end else if (r < 20) begin
                b = 8'($urandom_range(8'hF8, 8'hFF));
            end else if (r < 23) begin
                b = 8'($urandom_range(8'hF0, 8'hF7));
            end else if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 2))
                    0: b = 8'd0;
                    1: b = 8'd120;
                    default: b = 8'd123;
                endcase
            end else begin
                b = 8'($urandom_range(0, 127));
            end
            send(b);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            if ($urandom_range(0, 299) == 0) begin
                idle(3);
                do_reset_check("reset_random");
            end
        end

        idle(5);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_events: got %0d pending expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
